// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the core datapath: data width and the 4-bit ALU
// operation codes used by core_alu and by the blocks that drive it.
// No ports (package).
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_NE   = 4'd11;
    localparam logic [3:0] ALU_LT   = 4'd12;
    localparam logic [3:0] ALU_GE   = 4'd13;
    localparam logic [3:0] ALU_LTU  = 4'd14;
    localparam logic [3:0] ALU_GEU  = 4'd15;

endpackage

// File: rtl/core_alu.sv
// -----------------------------------------------------------------------------
// core_alu
// Purely combinational integer ALU. Shifts use the low five bits of op2;
// compare operations return 1 or 0 in bit 0.
// Ports:
//   alusel  in  4     operation code (core_pkg::ALU_*)
//   op1     in  XLEN  first operand
//   op2     in  XLEN  second operand / shift amount
//   result  out XLEN  operation result
// -----------------------------------------------------------------------------
module core_alu
    import core_pkg::*;
(
    input  logic [3:0]      alusel,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;
    logic       eq;

    assign shamt = op2[4:0];
    assign lt_s  = $signed(op1) < $signed(op2);
    assign lt_u  = op1 < op2;
    assign eq    = op1 == op2;

    always_comb begin
        // NOTE: result gets a value before the case so no path can leave it
        // unassigned and infer a latch.
        result = '0;
        case (alusel)
            ALU_ADD:         result = op1 + op2;
            ALU_SUB:         result = op1 - op2;
            ALU_SLL:         result = op1 << shamt;
            ALU_SLT, ALU_LT: result = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU,
            ALU_LTU:         result = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:         result = op1 ^ op2;
            ALU_SRL:         result = op1 >> shamt;
            ALU_SRA:         result = $unsigned($signed(op1) >>> shamt);
            ALU_OR:          result = op1 | op2;
            ALU_AND:         result = op1 & op2;
            ALU_EQ:          result = {{(XLEN-1){1'b0}}, eq};
            ALU_NE:          result = {{(XLEN-1){1'b0}}, !eq};
            ALU_GE:          result = {{(XLEN-1){1'b0}}, !lt_s};
            ALU_GEU:         result = {{(XLEN-1){1'b0}}, !lt_u};
        endcase
    end

endmodule

// File: rtl/core_alu_arb.sv
// -----------------------------------------------------------------------------
// core_alu_arb
// Time-shares one core_alu between two requesters (port 0 = execute stage,
// port 1 = branch/address unit). One operation is accepted per cycle; the
// result is returned through a single registered response slot tagged with
// the issuing port.
// Parameters:
//   FIXED_PRIO  0: round-robin on conflict, 1: port 0 always wins a conflict
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   rqN_valid / rqN_ready            request handshake, N = 0,1
//   rqN_alusel, rqN_op1, rqN_op2     operation code and operands
//   rqN_lock                         keep the grant for this port's next request
//   rs_valid / rs_ready              response handshake
//   rs_id, rs_result                 issuing port and ALU result
// -----------------------------------------------------------------------------
module core_alu_arb
    import core_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rq0_valid,
    output logic            rq0_ready,
    input  logic [3:0]      rq0_alusel,
    input  logic [XLEN-1:0] rq0_op1,
    input  logic [XLEN-1:0] rq0_op2,
    input  logic            rq0_lock,
    input  logic            rq1_valid,
    output logic            rq1_ready,
    input  logic [3:0]      rq1_alusel,
    input  logic [XLEN-1:0] rq1_op1,
    input  logic [XLEN-1:0] rq1_op2,
    input  logic            rq1_lock,
    output logic            rs_valid,
    input  logic            rs_ready,
    output logic            rs_id,
    output logic [XLEN-1:0] rs_result
);

    logic            last_grant_q, last_grant_d;
    logic            lock_vld_q,   lock_vld_d;
    logic            lock_id_q,    lock_id_d;
    logic            rs_valid_q,   rs_valid_d;
    logic            rs_id_q,      rs_id_d;
    logic [XLEN-1:0] rs_result_q,  rs_result_d;

    logic [1:0]      req_valid;
    logic [1:0]      grant;
    logic            gnt_id;
    logic            gnt_lock;
    logic            can_issue;
    logic            accept;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] alu_op1;
    logic [XLEN-1:0] alu_op2;
    logic [XLEN-1:0] alu_result;

    assign req_valid = {rq1_valid, rq0_valid};

    // Grant: a lock owner only keeps priority while it is actually requesting,
    // so an idle owner never blocks the other port.
    always_comb begin
        grant = 2'b00;
        if (lock_vld_q && req_valid[lock_id_q]) begin
            grant = lock_id_q ? 2'b10 : 2'b01;
        end else if (req_valid == 2'b11) begin
            if (FIXED_PRIO) begin
                grant = 2'b01;
            end else begin
                grant = last_grant_q ? 2'b01 : 2'b10;
            end
        end else begin
            grant = req_valid;
        end
    end

    assign gnt_id    = grant[1];
    assign gnt_lock  = gnt_id ? rq1_lock : rq0_lock;
    assign can_issue = !rs_valid_q || rs_ready;
    assign rq0_ready = grant[0] && can_issue;
    assign rq1_ready = grant[1] && can_issue;
    assign accept    = (rq0_valid && rq0_ready) || (rq1_valid && rq1_ready);

    assign alu_sel = gnt_id ? rq1_alusel : rq0_alusel;
    assign alu_op1 = gnt_id ? rq1_op1    : rq0_op1;
    assign alu_op2 = gnt_id ? rq1_op2    : rq0_op2;

    core_alu u_alu (
        .alusel (alu_sel),
        .op1    (alu_op1),
        .op2    (alu_op2),
        .result (alu_result)
    );

    always_comb begin
        last_grant_d = last_grant_q;
        lock_vld_d   = lock_vld_q;
        lock_id_d    = lock_id_q;
        rs_valid_d   = rs_valid_q;
        rs_id_d      = rs_id_q;
        rs_result_d  = rs_result_q;
        if (accept) begin
            // An accept overwrites the slot even while it is being drained,
            // which is what gives back-to-back throughput without a bubble.
            rs_valid_d   = 1'b1;
            rs_id_d      = gnt_id;
            rs_result_d  = alu_result;
            last_grant_d = gnt_id;
            lock_vld_d   = gnt_lock;
            lock_id_d    = gnt_id;
        end else begin
            if (rs_ready) begin
                rs_valid_d = 1'b0;
            end
            if (lock_vld_q && !req_valid[lock_id_q]) begin
                lock_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the result register is reset too, since rs_result is
            // visible at the port and must read 0 after reset.
            last_grant_q <= 1'b1;
            lock_vld_q   <= 1'b0;
            lock_id_q    <= 1'b0;
            rs_valid_q   <= 1'b0;
            rs_id_q      <= 1'b0;
            rs_result_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            last_grant_q <= last_grant_d;
            lock_vld_q   <= lock_vld_d;
            lock_id_q    <= lock_id_d;
            rs_valid_q   <= rs_valid_d;
            rs_id_q      <= rs_id_d;
            rs_result_q  <= rs_result_d;
        end
    end

    assign rs_valid  = rs_valid_q;
    assign rs_id     = rs_id_q;
    assign rs_result = rs_result_q;

endmodule

// File: tb/tb_core_alu_arb.sv
// -----------------------------------------------------------------------------
// tb_core_alu_arb
// Drives a round-robin instance (u_rr) and a fixed-priority instance (u_fp)
// with the same stimulus. A behavioural model of each tracks grant, lock and
// response state per cycle; directed steps add constant expectations.
// -----------------------------------------------------------------------------
module tb_core_alu_arb;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rq0_valid, rq0_lock, rq1_valid, rq1_lock, rs_ready;
    logic [3:0]  rq0_alusel, rq1_alusel;
    logic [31:0] rq0_op1, rq0_op2, rq1_op1, rq1_op2;
    logic [1:0]  rq0_ready_o, rq1_ready_o, rs_valid_o, rs_id_o;
    logic [31:0] rs_result_o [2];

    always #5 clk = ~clk;

    core_alu_arb #(.FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready_o[0]), .rq0_alusel(rq0_alusel),
        .rq0_op1(rq0_op1), .rq0_op2(rq0_op2), .rq0_lock(rq0_lock),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready_o[0]), .rq1_alusel(rq1_alusel),
        .rq1_op1(rq1_op1), .rq1_op2(rq1_op2), .rq1_lock(rq1_lock),
        .rs_valid(rs_valid_o[0]), .rs_ready(rs_ready), .rs_id(rs_id_o[0]),
        .rs_result(rs_result_o[0])
    );

    core_alu_arb #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready_o[1]), .rq0_alusel(rq0_alusel),
        .rq0_op1(rq0_op1), .rq0_op2(rq0_op2), .rq0_lock(rq0_lock),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready_o[1]), .rq1_alusel(rq1_alusel),
        .rq1_op1(rq1_op1), .rq1_op2(rq1_op2), .rq1_lock(rq1_lock),
        .rs_valid(rs_valid_o[1]), .rs_ready(rs_ready), .rs_id(rs_id_o[1]),
        .rs_result(rs_result_o[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state per instance: index 0 = round-robin, 1 = fixed priority.
    bit          m_last   [2];
    bit          m_lock_v [2];
    bit          m_lock_id[2];
    bit          m_rs_v   [2];
    bit          m_rs_id  [2];
    logic [31:0] m_rs_res [2];
    bit          acc      [2];   // port accepted by u_rr in the last cycle

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
        int          sa, sb, sh;
        int unsigned ua, ub;
        sa = a;
        sb = b;
        ua = a;
        ub = b;
        sh = int'(b & 32'd31);
        case (sel)
            ALU_ADD:  return ua + ub;
            ALU_SUB:  return ua - ub;
            ALU_SLL:  return ua << sh;
            ALU_SLT:  return 32'(sa < sb);
            ALU_SLTU: return 32'(ua < ub);
            ALU_XOR:  return ua ^ ub;
            ALU_SRL:  return ua >> sh;
            ALU_SRA:  return sa >>> sh;
            ALU_OR:   return ua | ub;
            ALU_AND:  return ua & ub;
            ALU_EQ:   return 32'(ua == ub);
            ALU_NE:   return 32'(ua != ub);
            ALU_LT:   return 32'(sa < sb);
            ALU_GE:   return 32'(sa >= sb);
            ALU_LTU:  return 32'(ua < ub);
            default:  return 32'(ua >= ub);
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_last[d]    = 1'b1;
            m_lock_v[d]  = 1'b0;
            m_lock_id[d] = 1'b0;
            m_rs_v[d]    = 1'b0;
            m_rs_id[d]   = 1'b0;
            m_rs_res[d]  = '0;
        end
        acc[0] = 1'b0;
        acc[1] = 1'b0;
    endtask

    // One clock cycle: check readies against the model before the edge,
    // advance the model, then check the response registers after the edge.
    task automatic cycle();
        bit          v[2], lk[2];
        logic [3:0]  sel[2];
        logic [31:0] a[2], b[2];
        v[0] = rq0_valid;  v[1] = rq1_valid;
        lk[0] = rq0_lock;  lk[1] = rq1_lock;
        sel[0] = rq0_alusel; sel[1] = rq1_alusel;
        a[0] = rq0_op1; a[1] = rq1_op1;
        b[0] = rq0_op2; b[1] = rq1_op2;
        #1;
        for (int d = 0; d < 2; d++) begin
            int g;
            bit can;
            g = -1;
            if (m_lock_v[d] && v[m_lock_id[d]])   g = int'(m_lock_id[d]);
            else if (v[0] && v[1])                g = (d == 1) ? 0 : (m_last[d] ? 0 : 1);
            else if (v[0])                        g = 0;
            else if (v[1])                        g = 1;
            can = !m_rs_v[d] || rs_ready;
            check_bit($sformatf("rq0_ready[%0d]", d), rq0_ready_o[d], (g == 0) && can);
            check_bit($sformatf("rq1_ready[%0d]", d), rq1_ready_o[d], (g == 1) && can);
            if (g >= 0 && can) begin
                m_rs_res[d]  = alu_ref(sel[g], a[g], b[g]);
                m_rs_v[d]    = 1'b1;
                m_rs_id[d]   = (g == 1);
                m_last[d]    = (g == 1);
                m_lock_v[d]  = lk[g];
                m_lock_id[d] = (g == 1);
                if (d == 0) begin
                    acc[0] = (g == 0);
                    acc[1] = (g == 1);
                end
            end else begin
                if (m_rs_v[d] && rs_ready)            m_rs_v[d] = 1'b0;
                if (m_lock_v[d] && !v[m_lock_id[d]])  m_lock_v[d] = 1'b0;
                if (d == 0) begin
                    acc[0] = 1'b0;
                    acc[1] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_bit($sformatf("rs_valid[%0d]", d), rs_valid_o[d], m_rs_v[d]);
            check_bit($sformatf("rs_id[%0d]", d), rs_id_o[d], m_rs_id[d]);
            check($sformatf("rs_result[%0d]", d), rs_result_o[d], m_rs_res[d]);
        end
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic gen_req(input int p);
        logic       v, l;
        logic [3:0] s;
        v = ($urandom_range(0, 3) != 0);
        l = ($urandom_range(0, 3) == 0);
        s = 4'($urandom_range(0, 15));
        if (p == 0) begin
            rq0_valid = v; rq0_lock = l; rq0_alusel = s;
            rq0_op1 = rnd_op(); rq0_op2 = rnd_op();
        end else begin
            rq1_valid = v; rq1_lock = l; rq1_alusel = s;
            rq1_op1 = rnd_op(); rq1_op2 = rnd_op();
        end
    endtask

    initial begin
        // ---- reset state ----
        rst_n = 1'b0;
        rq0_valid = 0; rq0_lock = 0; rq0_alusel = '0; rq0_op1 = '0; rq0_op2 = '0;
        rq1_valid = 0; rq1_lock = 0; rq1_alusel = '0; rq1_op1 = '0; rq1_op2 = '0;
        rs_ready = 1'b1;
        model_reset();
        #2;
        check_bit("reset rs_valid", rs_valid_o[0], 1'b0);
        check_bit("reset rs_id", rs_id_o[0], 1'b0);
        check("reset rs_result", rs_result_o[0], 32'h0);
        check_bit("reset rq0_ready", rq0_ready_o[0], 1'b0);
        check_bit("reset rq1_ready", rq1_ready_o[0], 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---- port 0 only: ADD 5 + 7 ----
        rq0_valid = 1; rq0_alusel = ALU_ADD; rq0_op1 = 5; rq0_op2 = 7;
        cycle();
        check_bit("add rs_valid", rs_valid_o[0], 1'b1);
        check_bit("add rs_id", rs_id_o[0], 1'b0);
        check("add rs_result", rs_result_o[0], 32'd12);
        rq0_valid = 0;
        cycle();
        check_bit("add drained", rs_valid_o[0], 1'b0);

        // ---- short reset pulse so the next conflict starts from reset ----
        rst_n = 1'b0;
        #1;
        model_reset();
        #1;
        rst_n = 1'b1;

        // ---- both valid: round-robin on u_rr, fixed priority on u_fp ----
        rq0_valid = 1; rq0_alusel = ALU_SUB; rq0_op1 = 10; rq0_op2 = 3;
        rq1_valid = 1; rq1_alusel = ALU_SLT; rq1_op1 = 32'hFFFF_FFFF; rq1_op2 = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_bit($sformatf("rr id %0d", i), rs_id_o[0], (i % 2) == 1);
            check($sformatf("rr result %0d", i), rs_result_o[0], (i % 2) ? 32'd1 : 32'd7);
            check_bit($sformatf("fp id %0d", i), rs_id_o[1], 1'b0);
            check($sformatf("fp result %0d", i), rs_result_o[1], 32'd7);
        end
        rq0_valid = 0;
        #1;
        check_bit("fp rq1_ready after drop", rq1_ready_o[1], 1'b1);
        cycle();

        // ---- lock: port 1 keeps the grant for three requests ----
        rq1_valid = 0;
        rq0_valid = 1; rq0_alusel = ALU_ADD; rq0_op1 = 1; rq0_op2 = 2;
        cycle();
        rq1_valid = 1; rq1_lock = 1; rq1_alusel = ALU_GEU; rq1_op1 = 32'hFFFF_FFFF; rq1_op2 = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_bit($sformatf("lock id %0d", i), rs_id_o[0], 1'b1);
            check($sformatf("lock result %0d", i), rs_result_o[0], 32'd1);
        end
        rq1_valid = 0; rq1_lock = 0;
        cycle();
        check_bit("lock released id", rs_id_o[0], 1'b0);
        check("lock released result", rs_result_o[0], 32'd3);

        // ---- backpressure: SRA result held, readies low ----
        rq0_alusel = ALU_SRA; rq0_op1 = 32'h8000_0000; rq0_op2 = 4;
        cycle();
        check("sra result", rs_result_o[0], 32'hF800_0000);
        rq0_valid = 0;
        rq1_valid = 1; rq1_alusel = ALU_OR; rq1_op1 = 32'h0F; rq1_op2 = 32'hF0;
        rs_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("bp hold %0d", i), rs_result_o[0], 32'hF800_0000);
            check_bit($sformatf("bp valid %0d", i), rs_valid_o[0], 1'b1);
            check_bit($sformatf("bp rq1_ready %0d", i), rq1_ready_o[0], 1'b0);
        end
        rs_ready = 1;
        #1;
        check_bit("bp release ready", rq1_ready_o[0], 1'b1);
        cycle();
        check_bit("bp accept valid", rs_valid_o[0], 1'b1);
        check_bit("bp accept id", rs_id_o[0], 1'b1);
        check("bp accept result", rs_result_o[0], 32'h0000_00FF);

        // ---- reset in the middle of traffic ----
        rq0_valid = 1; rq0_alusel = ALU_XOR; rq0_op1 = 32'hA5A5_A5A5; rq0_op2 = 32'hFFFF_0000;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("async rst rs_valid", rs_valid_o[0], 1'b0);
        check_bit("async rst rs_id", rs_id_o[0], 1'b0);
        check("async rst rs_result", rs_result_o[0], 32'h0);
        model_reset();
        #2;
        rst_n = 1'b1;
        #1;
        check_bit("post rst port0 wins", rq0_ready_o[0], 1'b1);
        cycle();
        check_bit("post rst id", rs_id_o[0], 1'b0);
        check("post rst result", rs_result_o[0], 32'h5A5A_A5A5);

        // ---- randomized traffic against the model ----
        rq0_lock = 0;
        for (int i = 0; i < 400; i++) begin
            if (!rq0_valid || acc[0]) gen_req(0);
            if (!rq1_valid || acc[1]) gen_req(1);
            rs_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
